// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Two-requester round-robin front end for a single shared APB master.
//   Requester 0 is the CPU data port and requester 1 is DMA/debug. Each
//   transaction is granted, forwarded to the master, and completed with a
//   one-cycle done pulse to its owner. Completion comes either from the
//   master's m_done or from a timeout abort after TIMEOUT busy cycles.
//
// Ports
//   clk, rst                    rising-edge clock; asynchronous active-high reset
//   r0_* / r1_*                 requester valid/write/addr/wdata inputs, done pulses
//   s_rdata, s_err              response data/error, valid while rN_done is high
//   m_valid, m_write,
//   m_addr, m_wdata             request held toward the shared master
//   m_done, m_rdata             master completion and read data
//   busy                        high in every state except IDLE
//   grant_id                    requester currently owning the master
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic        r0_write,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_done,
    input  logic        r1_valid,
    input  logic        r1_write,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_done,
    output logic [31:0] s_rdata,
    output logic        s_err,
    output logic        m_valid,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_done,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] to_cnt;
    logic       last_grant;
    logic       pick;

    // Round-robin: on contention the requester not granted last wins;
    // otherwise whichever single requester is valid.
    always_comb begin
        pick = 1'b0;
        if (r0_valid && r1_valid)
            pick = ~last_grant;
        else
            pick = r1_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            to_cnt     <= '0;
            last_grant <= 1'b1;
            m_valid    <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            s_rdata    <= '0;
            s_err      <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        grant_id <= pick;
                        m_write  <= pick ? r1_write : r0_write;
                        m_addr   <= pick ? r1_addr  : r0_addr;
                        m_wdata  <= pick ? r1_wdata : r0_wdata;
                        m_valid  <= 1'b1;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // m_done is checked first so it wins a same-cycle timeout.
                    if (m_done || (to_cnt == TO_LAST)) begin
                        s_rdata    <= m_done ? m_rdata : '0;
                        s_err      <= ~m_done;
                        m_valid    <= 1'b0;
                        last_grant <= grant_id;
                        r0_done    <= ~grant_id;
                        r1_done    <= grant_id;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r0_done <= 1'b0;
                    r1_done <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r0_write = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0;
    logic        r1_valid = 1'b0, r1_write = 1'b0;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic        r0_done, r1_done;
    logic [31:0] s_rdata;
    logic        s_err;
    logic        m_valid, m_write;
    logic [31:0] m_addr, m_wdata;
    logic        m_done = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        busy, grant_id;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    apb_req_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_done(r0_done),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_done(r1_done),
        .s_rdata(s_rdata), .s_err(s_err),
        .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_done(m_done), .m_rdata(m_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold m_done low for n_wait busy cycles, then pulse it with rdata.
    task automatic master_respond(input int n_wait, input logic [31:0] rdata);
        m_done = 1'b0;
        for (int i = 0; i < n_wait; i++) tick();
        m_done  = 1'b1;
        m_rdata = rdata;
        tick();
        m_done  = 1'b0;
    endtask

    // Find the next done pulse, compare it with the scoreboard head, and
    // confirm the pulse is one cycle long with the block back in IDLE.
    task automatic wait_resp(input string tag);
        exp_t e;
        int   n = 0;
        while (!(r0_done || r1_done) && n < 50) begin
            tick();
            n++;
        end
        if (!(r0_done || r1_done)) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"}, {30'd0, r1_done, r0_done}, e.id ? 32'd2 : 32'd1);
            check({tag, "_rdata"}, s_rdata, e.rdata);
            check({tag, "_err"}, {31'd0, s_err}, {31'd0, e.err});
            tick();
            check({tag, "_pulse_end"}, {30'd0, r1_done, r0_done}, 32'd0);
            check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant_id}, 32'd0);
        check("rst_done", {30'd0, r1_done, r0_done}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_addr", m_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Contention: r0 first, then r1
        r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 32'h1000_0000; r0_wdata = 32'h0A0A_0A0A;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 32'h2000_0000; r1_wdata = 32'h0B0B_0B0B;
        tick();
        check("c1_grant", {31'd0, grant_id}, 32'd0);
        check("c1_addr", m_addr, 32'h1000_0000);
        check("c1_write", {31'd0, m_write}, 32'd1);
        check("c1_wdata", m_wdata, 32'h0A0A_0A0A);
        check("c1_m_valid", {31'd0, m_valid}, 32'd1);
        sb.push_back('{1'b0, 32'hAAAA_0001, 1'b0});
        master_respond(0, 32'hAAAA_0001);
        wait_resp("c1");
        tick();
        check("c2_grant", {31'd0, grant_id}, 32'd1);
        check("c2_addr", m_addr, 32'h2000_0000);
        check("c2_write", {31'd0, m_write}, 32'd0);
        sb.push_back('{1'b1, 32'hBBBB_0002, 1'b0});
        master_respond(1, 32'hBBBB_0002);
        wait_resp("c2");
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();

        // Single read, m_done after two busy cycles
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 32'h4000_0004;
        tick();
        r0_valid = 1'b0;
        check("rd_addr", m_addr, 32'h4000_0004);
        check("rd_grant", {31'd0, grant_id}, 32'd0);
        sb.push_back('{1'b0, 32'h1234_5678, 1'b0});
        master_respond(1, 32'h1234_5678);
        wait_resp("rd");

        // Timeout: four busy cycles, then abort with err and zero data
        m_rdata = 32'hDEAD_BEEF;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 32'h3000_0000;
        tick();
        r1_valid = 1'b0;
        begin
            int n = 0;
            while (m_valid && n < 20) begin
                n++;
                tick();
            end
            check("to_busy_cycles", n, 32'd4);
        end
        sb.push_back('{1'b1, 32'h0, 1'b1});
        wait_resp("to");

        // Timeout tie: m_done on the last counted cycle wins
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 32'h5000_0000;
        tick();
        r0_valid = 1'b0;
        sb.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
        master_respond(3, 32'hCAFE_F00D);
        wait_resp("tie");

        // Stability of the held request while requester inputs change
        r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 32'h6000_0010; r0_wdata = 32'h1111_2222;
        tick();
        r0_valid = 1'b0; r0_write = 1'b0; r0_addr = 32'h7777_7777; r0_wdata = 32'h3333_4444;
        tick();
        check("st_addr_busy", m_addr, 32'h6000_0010);
        check("st_wdata_busy", m_wdata, 32'h1111_2222);
        check("st_write_busy", {31'd0, m_write}, 32'd1);
        sb.push_back('{1'b0, 32'h5555_6666, 1'b0});
        master_respond(0, 32'h5555_6666);
        check("st_addr_resp", m_addr, 32'h6000_0010);
        wait_resp("st");

        // Stray m_done in IDLE: no pulse, response registers hold
        m_done = 1'b1; m_rdata = 32'h9999_9999;
        tick();
        check("stray_done", {30'd0, r1_done, r0_done}, 32'd0);
        check("stray_busy", {31'd0, busy}, 32'd0);
        tick();
        check("stray_done2", {30'd0, r1_done, r0_done}, 32'd0);
        check("hold_rdata", s_rdata, 32'h5555_6666);
        m_done = 1'b0;

        // Reset mid-BUSY aborts without a done pulse
        r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 32'h8000_0000; r1_wdata = 32'h1357_9BDF;
        tick();
        r1_valid = 1'b0;
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mr_m_valid", {31'd0, m_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_grant", {31'd0, grant_id}, 32'd0);
        check("mr_addr", m_addr, 32'd0);
        check("mr_wdata", m_wdata, 32'd0);
        check("mr_write", {31'd0, m_write}, 32'd0);
        check("mr_rdata", s_rdata, 32'd0);
        check("mr_err", {31'd0, s_err}, 32'd0);
        m_done = 1'b1;
        tick();
        check("mr_done", {30'd0, r1_done, r0_done}, 32'd0);
        m_done = 1'b0;
        rst = 1'b0;
        tick();
        check("mr_done_after", {30'd0, r1_done, r0_done}, 32'd0);

        // First contention after reset goes to r0
        r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 32'hA000_0000;
        r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 32'hB000_0000;
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        check("pr_grant", {31'd0, grant_id}, 32'd0);
        check("pr_addr", m_addr, 32'hA000_0000);
        sb.push_back('{1'b0, 32'h0F0F_0F0F, 1'b0});
        master_respond(0, 32'h0F0F_0F0F);
        wait_resp("pr");

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
